// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB register completer: register offsets,
// CTRL bit positions, the bus FSM state type and address decode helpers.
package apb_reg_pkg;

    localparam logic [7:0] CTRL_OFS     = 8'h00;
    localparam logic [7:0] STATUS_OFS   = 8'h04;
    localparam logic [7:0] INT_STAT_OFS = 8'h08;
    localparam logic [7:0] INT_EN_OFS   = 8'h0C;
    localparam logic [7:0] SCRATCH_OFS  = 8'h10;
    localparam logic [7:0] COUNTER_OFS  = 8'h14;

    localparam int unsigned CTRL_CNT_EN_BIT = 0;

    typedef enum logic {IDLE, ACCESS} apb_state_e;

    function automatic logic ofs_is_mapped(input logic [7:0] ofs);
        return (ofs == CTRL_OFS)    || (ofs == STATUS_OFS)  ||
               (ofs == INT_STAT_OFS) || (ofs == INT_EN_OFS) ||
               (ofs == SCRATCH_OFS) || (ofs == COUNTER_OFS);
    endfunction

    function automatic logic ofs_is_read_only(input logic [7:0] ofs);
        return (ofs == STATUS_OFS) || (ofs == COUNTER_OFS);
    endfunction

endpackage

// File: rtl/apb_reg_file.sv
// Register file behind the APB completer.
// Holds CTRL, INT_STAT (W1C, hardware set wins), INT_EN, SCRATCH, the
// free-running COUNTER and the registered interrupt output.
// Ports:
//   clk_i, rst_ni   clock / async active-low reset
//   wr_en_i         commit a write this edge (already error-filtered)
//   rd_en_i         present read data on rdata_o (otherwise rdata_o = 0)
//   write_i         transfer direction, used for the read-only error check
//   addr_i          byte offset PADDR[7:0]
//   wdata_i         write data
//   hw_status_i     live STATUS value
//   hw_event_i      per-bit event pulses into INT_STAT
//   rdata_o, err_o  read data and decode error for the current address
//   ctrl_o, irq_o   CTRL value and registered interrupt
module apb_reg_file
    import apb_reg_pkg::*;
#(
    parameter int unsigned        DATA_W   = 32,
    parameter logic [DATA_W-1:0]  CTRL_RST = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              write_i,
    input  logic [7:0]        addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] hw_status_i,
    input  logic [DATA_W-1:0] hw_event_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [DATA_W-1:0] ctrl_o,
    output logic              irq_o
);

    logic [DATA_W-1:0] ctrl_q,     ctrl_d;
    logic [DATA_W-1:0] int_stat_q, int_stat_d;
    logic [DATA_W-1:0] int_en_q,   int_en_d;
    logic [DATA_W-1:0] scratch_q,  scratch_d;
    logic [DATA_W-1:0] counter_q,  counter_d;
    logic              irq_q,      irq_d;

    always_comb begin
        err_o = !ofs_is_mapped(addr_i) || (addr_i[1:0] != 2'b00) ||
                (write_i && ofs_is_read_only(addr_i));
    end

    always_comb begin
        rdata_o = '0;
        if (rd_en_i) begin
            case (addr_i)
                CTRL_OFS:     rdata_o = ctrl_q;
                STATUS_OFS:   rdata_o = hw_status_i;
                INT_STAT_OFS: rdata_o = int_stat_q;
                INT_EN_OFS:   rdata_o = int_en_q;
                SCRATCH_OFS:  rdata_o = scratch_q;
                COUNTER_OFS:  rdata_o = counter_q;
                default:      rdata_o = '0;
            endcase
        end
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        int_stat_d = int_stat_q;
        int_en_d   = int_en_q;
        scratch_d  = scratch_q;
        if (wr_en_i) begin
            case (addr_i)
                CTRL_OFS:     ctrl_d     = wdata_i;
                INT_STAT_OFS: int_stat_d = int_stat_q & ~wdata_i;
                INT_EN_OFS:   int_en_d   = wdata_i;
                SCRATCH_OFS:  scratch_d  = wdata_i;
                default:      ;
            endcase
        end
        // Applied after the W1C clear so a coincident event keeps its bit set.
        int_stat_d = int_stat_d | hw_event_i;
        counter_d  = ctrl_q[CTRL_CNT_EN_BIT] ? counter_q + DATA_W'(1) : counter_q;
        irq_d      = |(int_stat_q & int_en_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q     <= CTRL_RST;
            int_stat_q <= '0;
            int_en_q   <= '0;
            scratch_q  <= '0;
            counter_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            int_stat_q <= int_stat_d;
            int_en_q   <= int_en_d;
            scratch_q  <= scratch_d;
            counter_q  <= counter_d;
            irq_q      <= irq_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer for the RAL test target: bus FSM with programmable wait
// states, response generation and the register file instance.
// Ports:
//   PCLK, PRESETn                     clock / async active-low reset
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA                            APB request
//   PRDATA, PREADY, PSLVERR           APB response
//   hw_status_i                       live STATUS value
//   hw_event_i                        interrupt event pulses
//   ctrl_o                            current CTRL value
//   irq_o                             registered |(INT_STAT & INT_EN)
module apb_reg_completer
    import apb_reg_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        WAIT_STATES = 0,
    parameter logic [DATA_W-1:0]  CTRL_RST    = '0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [DATA_W-1:0] hw_status_i,
    input  logic [DATA_W-1:0] hw_event_i,
    output logic [DATA_W-1:0] ctrl_o,
    output logic              irq_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    apb_state_e  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic              addr_hi_err;
    logic              rf_err;
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [DATA_W-1:0] rf_rdata;

    // Only PADDR[7:0] is decoded; anything above must be zero.
    assign addr_hi_err = |(PADDR >> 8);

    assign PREADY   = (state_q == ACCESS) && PSEL && PENABLE && (wait_cnt_q == '0);
    assign PSLVERR  = PREADY && (addr_hi_err || rf_err);
    assign rf_wr_en = PREADY && PWRITE && !PSLVERR;
    assign rf_rd_en = PREADY && !PWRITE && !PSLVERR;
    assign PRDATA   = rf_rdata;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d    = ACCESS;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            ACCESS: begin
                // Deselect mid-access abandons the transfer without a response.
                if (!PSEL || PREADY) begin
                    state_d = IDLE;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    apb_reg_file #(
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_regs (
        .clk_i       (PCLK),
        .rst_ni      (PRESETn),
        .wr_en_i     (rf_wr_en),
        .rd_en_i     (rf_rd_en),
        .write_i     (PWRITE),
        .addr_i      (PADDR[7:0]),
        .wdata_i     (PWDATA),
        .hw_status_i (hw_status_i),
        .hw_event_i  (hw_event_i),
        .rdata_o     (rf_rdata),
        .err_o       (rf_err),
        .ctrl_o      (ctrl_o),
        .irq_o       (irq_o)
    );

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer. Three instances share the bus
// signals except PSEL: index 0 has no wait states, index 1 has three
// (and a nonzero CTRL reset value), index 2 has two.
module tb_apb_reg_completer;

    localparam logic [31:0] HW_STATUS = 32'h1234_5678;

    logic        pclk;
    logic        presetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] hw_status;
    logic [31:0] hw_event;

    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [31:0] ctrl    [3];
    logic        irq     [3];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    apb_reg_completer #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0), .CTRL_RST(32'h0)) dut0 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]), .hw_status_i(hw_status), .hw_event_i(hw_event),
        .ctrl_o(ctrl[0]), .irq_o(irq[0]));

    apb_reg_completer #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(3), .CTRL_RST(32'h0000_0100)) dut1 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]), .hw_status_i(hw_status), .hw_event_i(hw_event),
        .ctrl_o(ctrl[1]), .irq_o(irq[1]));

    apb_reg_completer #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(2), .CTRL_RST(32'h0)) dut2 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
        .PSLVERR(pslverr[2]), .hw_status_i(hw_status), .hw_event_i(hw_event),
        .ctrl_o(ctrl[2]), .irq_o(irq[2]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One APB transfer on instance s. Returns at the completion cycle (after
    // the sampling point, before the commit edge) so a following call is
    // back-to-back.
    task automatic apb_xfer(input int s, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd,
                            output logic er, output int waits, output int at_cyc,
                            output logic early_nz);
        @(negedge pclk);
        psel    = 3'b000;
        psel[s] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(negedge pclk);
        penable  = 1'b1;
        waits    = 0;
        early_nz = 1'b0;
        #2;
        while (!pready[s] && waits < 40) begin
            if (prdata[s] != 32'h0) early_nz = 1'b1;
            waits++;
            @(negedge pclk);
            #2;
        end
        chk($sformatf("xfer_timeout_dut%0d_%08h", s, a), {31'h0, pready[s]}, 32'h1);
        rd     = prdata[s];
        er     = pslverr[s];
        at_cyc = cyc;
    endtask

    task automatic bus_idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            psel    = 3'b000;
            penable = 1'b0;
        end
    endtask

    logic [31:0] rd, cnt_a, cnt_b;
    logic        er, enz, saw_ready;
    int          w, ca, cb;

    initial begin
        presetn   = 1'b0;
        psel      = 3'b000;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        hw_status = HW_STATUS;
        hw_event  = '0;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0,          1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,          HW_STATUS,      1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,          32'h0,          1'b0};
        vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,          32'h0,          1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,          32'h0,          1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0,          32'h0,          1'b0};
        vecs[6]  = '{1'b1, 32'h0000_000C, 32'hA5A5_5A5A,  32'h0,          1'b0};
        vecs[7]  = '{1'b0, 32'h0000_000C, 32'h0,          32'hA5A5_5A5A,  1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0004, 32'h0000_0001,  32'h0,          1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0,          HW_STATUS,      1'b0};
        vecs[10] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  32'h0,          1'b0};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF,  1'b0};
        vecs[12] = '{1'b1, 32'h0000_0014, 32'h0000_0005,  32'h0,          1'b1};
        vecs[13] = '{1'b0, 32'h0000_0014, 32'h0,          32'h0,          1'b0};
        vecs[14] = '{1'b0, 32'h0000_0018, 32'h0,          32'h0,          1'b1};
        vecs[15] = '{1'b0, 32'h0000_0002, 32'h0,          32'h0,          1'b1};
        vecs[16] = '{1'b0, 32'h0000_0100, 32'h0,          32'h0,          1'b1};
        vecs[17] = '{1'b1, 32'h0000_0018, 32'h1111_1111,  32'h0,          1'b1};
        vecs[18] = '{1'b1, 32'h0000_0011, 32'h2222_2222,  32'h0,          1'b1};
        vecs[19] = '{1'b1, 32'h8000_0010, 32'h3333_3333,  32'h0,          1'b1};
        vecs[20] = '{1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF,  1'b0};
        vecs[21] = '{1'b1, 32'h0000_000C, 32'h0,          32'h0,          1'b0};

        repeat (3) @(negedge pclk);
        #2;
        chk("rst_pready",  {31'h0, pready[0]},  32'h0);
        chk("rst_pslverr", {31'h0, pslverr[0]}, 32'h0);
        chk("rst_prdata",  prdata[0],           32'h0);
        chk("rst_ctrl0",   ctrl[0],             32'h0);
        chk("rst_ctrl1",   ctrl[1],             32'h0000_0100);
        chk("rst_irq",     {31'h0, irq[0]},     32'h0);
        @(negedge pclk);
        presetn = 1'b1;

        // Register map, access errors and zero-wait latency.
        for (int i = 0; i < NV; i++) begin
            apb_xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, w, ca, enz);
            chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_waits", i), 32'(w), 32'h0);
        end
        bus_idle(1);

        // Three wait states.
        apb_xfer(1, 1'b0, 32'h0, 32'h0, rd, er, w, ca, enz);
        chk("ws3_ctrl_rst", rd, 32'h0000_0100);
        apb_xfer(1, 1'b1, 32'h10, 32'h0000_0055, rd, er, w, ca, enz);
        chk("ws3_wr_waits", 32'(w), 32'd3);
        apb_xfer(1, 1'b0, 32'h10, 32'h0, rd, er, w, ca, enz);
        chk("ws3_rd_waits", 32'(w), 32'd3);
        chk("ws3_rd_data", rd, 32'h0000_0055);
        chk("ws3_early_prdata", {31'h0, enz}, 32'h0);
        bus_idle(1);

        // Interrupts: set, set-wins-over-clear, W1C clear.
        apb_xfer(0, 1'b1, 32'h0C, 32'h0000_0004, rd, er, w, ca, enz);
        bus_idle(1);
        @(negedge pclk);
        hw_event = 32'h5;
        @(negedge pclk);
        hw_event = 32'h0;
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, er, w, ca, enz);
        chk("int_stat_set", rd, 32'h5);
        chk("irq_set", {31'h0, irq[0]}, 32'h1);
        hw_event = 32'h4;
        apb_xfer(0, 1'b1, 32'h08, 32'h0000_0004, rd, er, w, ca, enz);
        @(posedge pclk);
        #1 hw_event = 32'h0;
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, er, w, ca, enz);
        chk("int_stat_set_wins", rd, 32'h5);
        apb_xfer(0, 1'b1, 32'h08, 32'h0000_0005, rd, er, w, ca, enz);
        bus_idle(2);
        #2;
        chk("irq_cleared", {31'h0, irq[0]}, 32'h0);
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, er, w, ca, enz);
        chk("int_stat_cleared", rd, 32'h0);

        // Counter: first value after enable, rate, wrap.
        apb_xfer(0, 1'b1, 32'h00, 32'h0000_0001, rd, er, w, ca, enz);
        apb_xfer(0, 1'b0, 32'h14, 32'h0, cnt_a, er, w, ca, enz);
        chk("ctrl_o_en", ctrl[0], 32'h1);
        chk("counter_first", cnt_a, 32'h1);
        bus_idle(10);
        apb_xfer(0, 1'b0, 32'h14, 32'h0, cnt_b, er, w, cb, enz);
        chk("counter_rate", cnt_b - cnt_a, 32'(cb - ca));
        @(negedge pclk);
        psel = 3'b000;
        penable = 1'b0;
        force dut0.u_regs.counter_q = 32'hFFFF_FFFD;
        @(negedge pclk);
        release dut0.u_regs.counter_q;
        apb_xfer(0, 1'b0, 32'h14, 32'h0, rd, er, w, ca, enz);
        chk("counter_max", rd, 32'hFFFF_FFFF);
        apb_xfer(0, 1'b0, 32'h14, 32'h0, rd, er, w, ca, enz);
        chk("counter_wrap", rd, 32'h0000_0001);
        apb_xfer(0, 1'b1, 32'h00, 32'h0000_0000, rd, er, w, ca, enz);
        bus_idle(1);

        // Deselect during wait states: no commit, no response.
        @(negedge pclk);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0000_0099;
        @(negedge pclk);
        penable = 1'b1;
        saw_ready = 1'b0;
        #2 saw_ready = saw_ready | pready[1];
        @(negedge pclk);
        #2 saw_ready = saw_ready | pready[1];
        bus_idle(3);
        chk("abort_no_ready", {31'h0, saw_ready}, 32'h0);
        apb_xfer(1, 1'b0, 32'h10, 32'h0, rd, er, w, ca, enz);
        chk("abort_no_commit", rd, 32'h0000_0055);
        bus_idle(1);

        // Reset in the middle of a waited access.
        apb_xfer(0, 1'b1, 32'h00, 32'h0000_0002, rd, er, w, ca, enz);
        apb_xfer(0, 1'b1, 32'h0C, 32'h0000_0001, rd, er, w, ca, enz);
        bus_idle(1);
        hw_event = 32'h1;
        @(negedge pclk);
        hw_event = 32'h0;
        bus_idle(2);
        #2;
        chk("pre_rst_irq", {31'h0, irq[0]}, 32'h1);
        chk("pre_rst_ctrl", ctrl[0], 32'h2);
        @(negedge pclk);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0000_0077;
        @(negedge pclk);
        penable = 1'b1;
        #2 chk("ws2_waiting", {31'h0, pready[2]}, 32'h0);
        @(negedge pclk);
        #1 presetn = 1'b0;
        #1;
        chk("rst_mid_pready", {31'h0, pready[2]}, 32'h0);
        chk("rst_mid_ctrl",   ctrl[0],            32'h0);
        chk("rst_mid_irq",    {31'h0, irq[0]},    32'h0);
        @(negedge pclk);
        psel = 3'b000; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        apb_xfer(2, 1'b0, 32'h10, 32'h0, rd, er, w, ca, enz);
        chk("rst_lost_write", rd, 32'h0);
        chk("rst_ws2_waits", 32'(w), 32'd2);
        apb_xfer(0, 1'b0, 32'h10, 32'h0, rd, er, w, ca, enz);
        chk("rst_scratch", rd, 32'h0);
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, er, w, ca, enz);
        chk("rst_int_en", rd, 32'h0);
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, er, w, ca, enz);
        chk("rst_int_stat", rd, 32'h0);
        bus_idle(2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
